clock_segment_capture: RTL
==========================

# clock_segment_capture

Capture-side counterpart to the segment-driven clock generator. Samples an external clock on `refclk`, measures each high/low run, run-length-merges identical periods, and emits 128-bit segment words in the same `{on_counts[47:0], off_counts[47:0], repeat_counts[31:0]}` layout the generator consumes. Loopback tests and Atticus readback therefore compare words directly. Sits between a `ybus` input pin and an outbound FIFO/pipe-out toward the PC.

## Interface
- `ON_W`, default 48: on-count width.
- `OFF_W`, default 48: off-count width.
- `REP_W`, default 32: repeat-count width; the word is `ON_W+OFF_W+REP_W` (128) bits.
- `Q_DEPTH`, default 4: output queue depth; must be a power of 2.
- `refclk`: in, 1. Sole clock.
- `reset`: in, 1. Synchronous, active-high; one clock, and reset is synchronous and active-high.
- `enable`: in, 1. Arms capture. A falling edge flushes.
- `clk_in`: in, 1. Asynchronous measured clock.
- `timeout_counts`: in, `OFF_W`. Low-run timeout; 0 disables it.
- `seg_dout`: out, 128. Head of the output queue.
- `seg_valid`: out, 1. Queue not empty.
- `seg_ready`: in, 1. Consumer accepts the head word.
- `overflow`: out, 1. Sticky; a word was dropped.
- `segs_emitted`: out, 32. Count of words pushed into the queue (wraps).
- `capturing`: out, 1. State is `S_HIGH` or `S_LOW`.

## Operation
- **Input path**
  - `clk_in` passes through a 2-FF synchronizer, then a registered previous-level copy.
  - `rise` = synced & ~prev; `fall` = ~synced & prev.
- **States**
  - `S_IDLE`: all counters clear. Goes to `S_ARM` when `enable` is high.
  - `S_ARM`: waits for `rise`, then goes to `S_HIGH` with `hi_cnt`=1. A partial high run present at arm time is discarded.
  - `S_HIGH`: `hi_cnt`++ per cycle. On `fall`, goes to `S_LOW` with `lo_cnt`=1.
  - `S_LOW`: `lo_cnt`++ per cycle.
    - On `rise`: close period (`hi_cnt`, `lo_cnt`), go to `S_HIGH` with `hi_cnt`=1.
    - If `timeout_counts`≠0 and `lo_cnt`==`timeout_counts`: close period (`hi_cnt`, `timeout_counts`), then go to `S_FLUSH` with the marker request set.
  - `S_FLUSH`: pushes the pending word (if valid), then the marker word {0,0,0} if requested, one push per cycle. Stalls while the queue is full; nothing is dropped here. Edges are ignored. Exits to `S_ARM` if `enable` is high, else to `S_IDLE`.
- **Close-period rule** (pending register `p_on`, `p_off`, `p_rep`, `p_vld`)
  - If `p_vld`, (`p_on`,`p_off`) equals the new period, and `p_rep`≠all-ones: `p_rep`++.
  - Otherwise push the pending word (if `p_vld`) and load the new period with `p_rep`=1.
  - A push in `S_HIGH`/`S_LOW` while the queue is full drops the word and sets `overflow`. Capture continues.
- **Disable**
  - `enable` low in `S_LOW`: close period (`hi_cnt`, `lo_cnt`), then go to `S_FLUSH` without a marker.
  - `enable` low in `S_HIGH`: discard the partial run, go to `S_FLUSH`.
  - `enable` low in `S_ARM`: go to `S_FLUSH`.
- **Arithmetic**
  - `hi_cnt` and `lo_cnt` saturate at all-ones.
  - A saturated count still merges only on exact equality.
  - Repeat counts never wrap.
- **Queue**
  - Push and pop in the same cycle are both honoured when the queue is full.
  - `seg_dout` is stable while `seg_valid` is high and `seg_ready` is low.

## Timing
- Reset values: state `S_IDLE`, `seg_valid`=0, `seg_dout`=0, `overflow`=0, `segs_emitted`=0, `capturing`=0, queue empty, `p_vld`=0.
- `reset` overrides every other input in the same cycle, including mid-flush.
- `overflow` also clears on the rising edge of `enable`.
- Pin to edge latency: a `clk_in` transition is sampled at edge *t* and `rise`/`fall` is asserted at *t*+2. The latency is constant, so run lengths are exact in `refclk` cycles.
- A push at edge *t* gives `seg_valid` high after edge *t* (registered queue, 1 cycle).
- Concurrent `rise` and timeout in the same cycle: `rise` wins.
- Concurrent `enable` low and `rise` in `S_LOW`: the period closes and flushes; the new high run is not started.

## Structure
- **Package `clock_segment_pkg`**
  - `ON_W`, `OFF_W`, `REP_W`.
  - Segment word struct with field offsets [127:80], [79:32], [31:0].
  - State enum.
  - Marker constant (all-zero).
  - Shared with the generator side.
- **Sub-module `seg_out_queue`**
  - Synchronous FIFO, `Q_DEPTH` entries, 128-bit.
  - Ports: push, pop, full, empty, dout.

## Test plan
- `clk_in` high 3 / low 5 for 4 periods, then `enable` dropped in the 5th low run at `lo_cnt`=2 → words (3,5,4) then (3,2,1); `segs_emitted`=2.
- 3/5 ×2 then 2/2 ×3, then disable during a high run → (3,5,2) and (2,2,3); the partial run is discarded.
- `timeout_counts`=100; 4/4 ×2, then `clk_in` held low → (4,4,2), (4,100,1), (0,0,0); state back to `S_ARM` and `capturing`=0.
- `seg_ready`=0, `Q_DEPTH`=4, alternating 2/2 and 3/3 periods → 4 words queued, the 5th is dropped, `overflow`=1. Raising `seg_ready` drains words in order.
- `reset` asserted in `S_FLUSH` with the queue full → next cycle all outputs at reset values and the queue is empty.
- Loopback with the generator programmed as (10,6,1000) → single word (10,6,1000) after disable, bit-identical.

Source files
------------

// File: rtl/clock_segment_pkg.sv
// Shared definitions for the segment clock generator and capture blocks.
// A segment word is {on_counts, off_counts, repeat_counts}, MSB first.
package clock_segment_pkg;

  localparam int ON_W  = 48;
  localparam int OFF_W = 48;
  localparam int REP_W = 32;

  typedef struct packed {
    logic [ON_W-1:0]  on_counts;      // [127:80]
    logic [OFF_W-1:0] off_counts;     // [79:32]
    logic [REP_W-1:0] repeat_counts;  // [31:0]
  } seg_word_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_FLUSH = 3'd4
  } cap_state_t;

  // An all-zero word marks a timeout break in the captured stream.
  localparam seg_word_t SEG_MARKER = '0;

  function automatic seg_word_t make_seg(input logic [ON_W-1:0] on_c,
                                         input logic [OFF_W-1:0] off_c,
                                         input logic [REP_W-1:0] rep_c);
    seg_word_t w;
    w.on_counts     = on_c;
    w.off_counts    = off_c;
    w.repeat_counts = rep_c;
    return w;
  endfunction

endpackage

// File: rtl/seg_out_queue.sv
// Small synchronous FIFO holding finished segment words for the consumer.
// A push into a full queue is accepted when a pop happens in the same cycle.
module seg_out_queue #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         refclk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_en;
  logic          push_en;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until the count covers them.
  always_ff @(posedge refclk) begin
    if (push_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge refclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/clock_segment_capture.sv
// Measures high/low runs of an external clock and emits run-length merged
// segment words in the same layout the segment clock generator consumes.
module clock_segment_capture #(
  parameter int ON_W    = 48,
  parameter int OFF_W   = 48,
  parameter int REP_W   = 32,
  parameter int Q_DEPTH = 4
) (
  input  logic                        refclk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        clk_in,
  input  logic [OFF_W-1:0]            timeout_counts,
  output logic [ON_W+OFF_W+REP_W-1:0] seg_dout,
  output logic                        seg_valid,
  input  logic                        seg_ready,
  output logic                        overflow,
  output logic [31:0]                 segs_emitted,
  output logic                        capturing
);

  import clock_segment_pkg::*;

  localparam int WORD_W = ON_W + OFF_W + REP_W;

  logic              sync1, sync2, prev, en_q;
  logic              rise, fall;
  cap_state_t        state;
  logic [ON_W-1:0]   hi_cnt;
  logic [OFF_W-1:0]  lo_cnt;
  logic [ON_W-1:0]   p_on;
  logic [OFF_W-1:0]  p_off;
  logic [REP_W-1:0]  p_rep;
  logic              p_vld;
  logic              mark_req;
  logic              timeout_hit, close_req, merge, cap_push;
  logic              flush_pend, flush_mark;
  logic              q_push, q_pop, q_full, q_empty, q_room, drop;
  logic [WORD_W-1:0] q_din;

  // Two-flop synchronizer plus a previous-level copy for edge detection.
  always_ff @(posedge refclk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      sync1 <= clk_in;
      sync2 <= sync1;
      prev  <= sync2;
      en_q  <= enable;
    end
  end

  assign rise = sync2 && !prev;
  assign fall = !sync2 && prev;

  // A low run ends by rise, disable or timeout; at timeout lo_cnt equals timeout_counts.
  assign timeout_hit = (timeout_counts != '0) && (lo_cnt == timeout_counts);
  assign close_req   = (state == S_LOW) && (!enable || rise || timeout_hit);
  assign merge       = p_vld && (p_on == hi_cnt) && (p_off == lo_cnt) && (p_rep != '1);
  assign cap_push    = close_req && p_vld && !merge;
  assign flush_pend  = (state == S_FLUSH) && p_vld;
  assign flush_mark  = (state == S_FLUSH) && !p_vld && mark_req;

  assign q_pop  = seg_ready && seg_valid;
  assign q_room = !q_full || q_pop;
  assign q_push = (cap_push || flush_pend || flush_mark) && q_room;
  assign drop   = cap_push && !q_room;
  assign q_din  = flush_mark ? '0 : {p_on, p_off, p_rep};

  assign seg_valid = !q_empty;
  assign capturing = (state == S_HIGH) || (state == S_LOW);

  // Capture state machine: run counters, pending word merge and flush sequencing.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state    <= S_IDLE;
      hi_cnt   <= '0;
      lo_cnt   <= '0;
      p_on     <= '0;
      p_off    <= '0;
      p_rep    <= '0;
      p_vld    <= 1'b0;
      mark_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          hi_cnt   <= '0;
          lo_cnt   <= '0;
          p_vld    <= 1'b0;
          mark_req <= 1'b0;
          if (enable) state <= S_ARM;
        end
        S_ARM: begin
          if (!enable) begin
            state <= S_FLUSH;
          end else if (rise) begin
            state  <= S_HIGH;
            hi_cnt <= ON_W'(1);
          end
        end
        S_HIGH: begin
          if (!enable) begin
            state <= S_FLUSH;
          end else if (fall) begin
            state  <= S_LOW;
            lo_cnt <= OFF_W'(1);
          end else if (hi_cnt != '1) begin
            hi_cnt <= hi_cnt + ON_W'(1);
          end
        end
        S_LOW: begin
          if (close_req) begin
            if (merge) begin
              p_rep <= p_rep + REP_W'(1);
            end else begin
              p_on  <= hi_cnt;
              p_off <= lo_cnt;
              p_rep <= REP_W'(1);
              p_vld <= 1'b1;
            end
            if (!enable) begin
              state <= S_FLUSH;
            end else if (rise) begin
              state  <= S_HIGH;
              hi_cnt <= ON_W'(1);
            end else begin
              state    <= S_FLUSH;
              mark_req <= 1'b1;
            end
          end else if (lo_cnt != '1) begin
            lo_cnt <= lo_cnt + OFF_W'(1);
          end
        end
        S_FLUSH: begin
          if (flush_pend) begin
            if (q_room) p_vld <= 1'b0;
          end else if (flush_mark) begin
            if (q_room) mark_req <= 1'b0;
          end else begin
            state <= enable ? S_ARM : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status: sticky drop flag (cleared when capture is re-armed) and push counter.
  always_ff @(posedge refclk) begin
    if (reset) begin
      overflow     <= 1'b0;
      segs_emitted <= '0;
    end else begin
      if (q_push) segs_emitted <= segs_emitted + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
      end else if (enable && !en_q) begin
        overflow <= 1'b0;
      end
    end
  end

  seg_out_queue #(
    .W     (WORD_W),
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .refclk (refclk),
    .reset  (reset),
    .push   (q_push),
    .pop    (q_pop),
    .din    (q_din),
    .full   (q_full),
    .empty  (q_empty),
    .dout   (seg_dout)
  );

endmodule
